// File: rtl/xbar_out_sched_if.sv
// Bundle between the per-input selector stage, the scheduler and the crossbar:
// requests, beat activity, output readiness, and the scheduler's registered decisions.
interface xbar_out_sched_if #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
);
    logic [NUM_PORTS-1:0]        req_valid;
    logic [NUM_PORTS*PORT_W-1:0] req_dest;
    logic [NUM_PORTS-1:0]        beat_valid;
    logic [NUM_PORTS-1:0]        beat_last;
    logic [NUM_PORTS-1:0]        out_ready;
    logic [NUM_PORTS-1:0]        grant;
    logic [NUM_PORTS*PORT_W-1:0] out_sel;
    logic [NUM_PORTS-1:0]        out_busy;
    logic [NUM_PORTS-1:0]        timeout_pulse;

    modport master (
        output req_valid, req_dest, beat_valid, beat_last, out_ready,
        input  grant, out_sel, out_busy, timeout_pulse
    );

    modport slave (
        input  req_valid, req_dest, beat_valid, beat_last, out_ready,
        output grant, out_sel, out_busy, timeout_pulse
    );
endinterface

// File: rtl/xbar_out_sched.sv
// Per-output round-robin packet scheduler for the NUM_PORTS x NUM_PORTS crossbar.
// Optional stall watchdog (idle counters, timeout_pulse) enabled by XBAR_SCHED_TIMEOUT_EN.
module xbar_out_sched #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2,
    parameter int MAX_IDLE  = 64
) (
    input logic           clk,
    input logic           rst,
    xbar_out_sched_if.slave bus
);

    generate
        if (NUM_PORTS != 2**PORT_W || MAX_IDLE < 2 || MAX_IDLE > 65535) begin : g_bad_param
            $error("xbar_out_sched: illegal NUM_PORTS/PORT_W/MAX_IDLE combination");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t               state_q [NUM_PORTS];
    state_t               state_d [NUM_PORTS];
    logic [PORT_W-1:0]    ptr_q   [NUM_PORTS];
    logic [PORT_W-1:0]    ptr_d   [NUM_PORTS];
    // The owner register doubles as the out_sel register: both hold their value in IDLE.
    logic [PORT_W-1:0]    owner_q [NUM_PORTS];
    logic [PORT_W-1:0]    owner_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [NUM_PORTS-1:0] busy_q, busy_d;
    logic [NUM_PORTS-1:0] done;

    logic [NUM_PORTS-1:0] cand  [NUM_PORTS];
    logic [NUM_PORTS-1:0] found;
    logic [PORT_W-1:0]    win   [NUM_PORTS];

`ifdef XBAR_SCHED_TIMEOUT_EN
    localparam logic [15:0] IDLE_LAST = 16'(MAX_IDLE - 1);

    logic [15:0]          idle_q [NUM_PORTS];
    logic [15:0]          idle_d [NUM_PORTS];
    logic [NUM_PORTS-1:0] tpulse_q, tpulse_d;
`endif

    // cand[j][i]: input i is an ungranted head-of-packet aimed at output j.
    always_comb begin : candidates
        for (int j = 0; j < NUM_PORTS; j++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cand[j][i] = bus.req_valid[i]
                           && (bus.req_dest[i*PORT_W +: PORT_W] == PORT_W'(j))
                           && !grant_q[i];
            end
        end
    end

    always_comb begin : arbitrate
        for (int j = 0; j < NUM_PORTS; j++) begin
            found[j] = 1'b0;
            win[j]   = '0;
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (!found[j] && cand[j][PORT_W'(ptr_q[j] + PORT_W'(k))]) begin
                    found[j] = 1'b1;
                    win[j]   = PORT_W'(ptr_q[j] + PORT_W'(k));
                end
            end
        end
    end

    always_comb begin : fsm_next
        // NOTE: every variable gets a default before any branch, so no latch can be inferred.
        grant_d = grant_q;
        busy_d  = busy_q;
        done    = '0;
`ifdef XBAR_SCHED_TIMEOUT_EN
        tpulse_d = '0;
`endif
        for (int j = 0; j < NUM_PORTS; j++) begin
            state_d[j] = state_q[j];
            ptr_d[j]   = ptr_q[j];
            owner_d[j] = owner_q[j];
`ifdef XBAR_SCHED_TIMEOUT_EN
            idle_d[j]  = idle_q[j];
`endif
        end

        for (int j = 0; j < NUM_PORTS; j++) begin
            if (state_q[j] == IDLE) begin
                if (bus.out_ready[j] && found[j]) begin
                    state_d[j]      = BUSY;
                    owner_d[j]      = win[j];
                    grant_d[win[j]] = 1'b1;
                    busy_d[j]       = 1'b1;
`ifdef XBAR_SCHED_TIMEOUT_EN
                    idle_d[j]       = '0;
`endif
                end
            end else begin
                done[j] = bus.beat_valid[owner_q[j]] && bus.beat_last[owner_q[j]];
`ifdef XBAR_SCHED_TIMEOUT_EN
                // A coinciding last beat takes priority over the watchdog.
                if (!done[j]) begin
                    if (bus.beat_valid[owner_q[j]]) begin
                        idle_d[j] = '0;
                    end else if (bus.out_ready[j]) begin
                        if (idle_q[j] == IDLE_LAST) begin
                            done[j]     = 1'b1;
                            tpulse_d[j] = 1'b1;
                        end else begin
                            idle_d[j] = idle_q[j] + 16'd1;
                        end
                    end
                end
`endif
                if (done[j]) begin
                    state_d[j]          = IDLE;
                    grant_d[owner_q[j]] = 1'b0;
                    busy_d[j]           = 1'b0;
                    ptr_d[j]            = owner_q[j] + 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_q <= '0;
            busy_q  <= '0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                state_q[j] <= IDLE;
                ptr_q[j]   <= '0;
                owner_q[j] <= '0;
            end
        end else begin
            grant_q <= grant_d;
            busy_q  <= busy_d;
            for (int j = 0; j < NUM_PORTS; j++) begin
                state_q[j] <= state_d[j];
                ptr_q[j]   <= ptr_d[j];
                owner_q[j] <= owner_d[j];
            end
        end
    end

`ifdef XBAR_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tpulse_q <= '0;
            for (int j = 0; j < NUM_PORTS; j++) begin
                idle_q[j] <= '0;
            end
        end else begin
            tpulse_q <= tpulse_d;
            for (int j = 0; j < NUM_PORTS; j++) begin
                idle_q[j] <= idle_d[j];
            end
        end
    end

    assign bus.timeout_pulse = tpulse_q;
`else
    assign bus.timeout_pulse = '0;
`endif

    logic [NUM_PORTS*PORT_W-1:0] sel_flat;

    always_comb begin : pack_sel
        sel_flat = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            sel_flat[j*PORT_W +: PORT_W] = owner_q[j];
        end
    end

    assign bus.grant    = grant_q;
    assign bus.out_busy = busy_q;
    assign bus.out_sel  = sel_flat;

endmodule

// File: tb/tb_xbar_out_sched.sv
// Self-checking bench for xbar_out_sched: directed scenarios plus a randomized
// phase, all checked against a cycle-level behavioural model of the scheduling rules.
module tb_xbar_out_sched;

    localparam int N  = 4;
    localparam int W  = 2;
    localparam int MI = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    xbar_out_sched_if #(.NUM_PORTS(N), .PORT_W(W)) bus ();

    xbar_out_sched #(.NUM_PORTS(N), .PORT_W(W), .MAX_IDLE(MI)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_pass  = 0;
    int n_total = 0;
    int n_fail  = 0;

    // Reference model: who owns each output, where each output's search starts.
    int           m_owner [N];
    int           m_ptr   [N];
    int           m_idle  [N];
    bit           m_busy  [N];
    logic [N-1:0] m_grant;
    logic [N-1:0] m_tp;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [N-1:0] rv, input logic [N*W-1:0] rd,
                         input logic [N-1:0] bv, input logic [N-1:0] bl,
                         input logic [N-1:0] rdy);
        bus.req_valid  = rv;
        bus.req_dest   = rd;
        bus.beat_valid = bv;
        bus.beat_last  = bl;
        bus.out_ready  = rdy;
    endtask

    task automatic model_release(input int j);
        m_busy[j]           = 1'b0;
        m_grant[m_owner[j]] = 1'b0;
        m_ptr[j]            = (m_owner[j] + 1) % N;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_edge();
        logic [N-1:0] g_old;
        int o;
        int i;
        if (rst) begin
            for (int j = 0; j < N; j++) begin
                m_owner[j] = 0; m_ptr[j] = 0; m_idle[j] = 0; m_busy[j] = 1'b0;
            end
            m_grant = '0;
            m_tp    = '0;
            return;
        end
        g_old = m_grant;
        m_tp  = '0;
        for (int j = 0; j < N; j++) begin
            if (!m_busy[j]) begin
                if (bus.out_ready[j]) begin
                    for (int k = 0; k < N; k++) begin
                        i = (m_ptr[j] + k) % N;
                        if (!m_busy[j] && bus.req_valid[i] && !g_old[i]
                            && int'(bus.req_dest[i*W +: W]) == j) begin
                            m_busy[j]  = 1'b1;
                            m_owner[j] = i;
                            m_grant[i] = 1'b1;
                            m_idle[j]  = 0;
                        end
                    end
                end
            end else begin
                o = m_owner[j];
                if (bus.beat_valid[o] && bus.beat_last[o]) begin
                    model_release(j);
                end
`ifdef XBAR_SCHED_TIMEOUT_EN
                else if (bus.beat_valid[o]) begin
                    m_idle[j] = 0;
                end else if (bus.out_ready[j]) begin
                    if (m_idle[j] == MI - 1) begin
                        model_release(j);
                        m_tp[j] = 1'b1;
                    end else begin
                        m_idle[j]++;
                    end
                end
`endif
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0]   exp_busy;
        logic [N*W-1:0] exp_sel;
        model_edge();
        @(posedge clk);
        #1;
        for (int j = 0; j < N; j++) begin
            exp_busy[j]       = m_busy[j];
            exp_sel[j*W +: W] = W'(m_owner[j]);
        end
        check("grant",         32'(bus.grant),         32'(m_grant));
        check("out_busy",      32'(bus.out_busy),      32'(exp_busy));
        check("out_sel",       32'(bus.out_sel),       32'(exp_sel));
        check("timeout_pulse", 32'(bus.timeout_pulse), 32'(m_tp));
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        drive('0, '0, '0, '0, 4'b1111);
        tick();
        tick();
        check("rst_grant",  32'(bus.grant),    32'h0);
        check("rst_busy",   32'(bus.out_busy), 32'h0);
        check("rst_outsel", 32'(bus.out_sel),  32'h0);
        rst = 1'b0;

        // Single request: input 0 -> output 2, 3-beat packet
        drive(4'b0001, 8'b00_00_00_10, '0, '0, 4'b1111);
        tick();
        check("single_grant",  32'(bus.grant),         32'b0001);
        check("single_busy",   32'(bus.out_busy),      32'b0100);
        check("single_outsel", 32'(bus.out_sel[5:4]),  32'd0);
        drive('0, '0, 4'b0001, 4'b0000, 4'b1111);
        tick();
        tick();
        drive('0, '0, 4'b0001, 4'b0001, 4'b1111);
        tick();
        check("single_release", 32'(bus.grant), 32'b0000);
        drive('0, '0, '0, '0, 4'b1111);
        tick();

        // Contention on output 0: inputs 1 and 3
        drive(4'b1010, 8'b00_00_00_00, '0, '0, 4'b1111);
        tick();
        check("rr_first", 32'(bus.grant), 32'b0010);
        drive(4'b1000, 8'b00_00_00_00, 4'b0010, 4'b0010, 4'b1111);
        tick();
        check("rr_release", 32'(bus.grant), 32'b0000);
        drive(4'b1000, 8'b00_00_00_00, '0, '0, 4'b1111);
        tick();
        check("rr_second",        32'(bus.grant),       32'b1000);
        check("rr_second_outsel", 32'(bus.out_sel[1:0]), 32'd3);
        drive('0, '0, 4'b1000, 4'b1000, 4'b1111);
        tick();
        drive(4'b1010, 8'b00_00_00_00, '0, '0, 4'b1111);
        tick();
        tick();
        check("rr_wrap", 32'(bus.grant), 32'b0010);
        drive('0, '0, 4'b0010, 4'b0010, 4'b1111);
        tick();
        drive('0, '0, '0, '0, 4'b1111);
        tick();

        // Parallel outputs: inputs 0..3 -> outputs 3..0
        drive(4'b1111, 8'b00_01_10_11, '0, '0, 4'b1111);
        tick();
        check("par_grant",  32'(bus.grant),    32'b1111);
        check("par_outsel", 32'(bus.out_sel),  32'b00_01_10_11);
        drive('0, '0, 4'b1111, 4'b1111, 4'b1111);
        tick();
        check("par_release", 32'(bus.grant), 32'b0000);
        drive('0, '0, '0, '0, 4'b1111);
        tick();

        // Backpressure on output 1
        drive(4'b0100, 8'b00_01_00_00, '0, '0, 4'b1101);
        tick();
        tick();
        tick();
        check("bp_hold", 32'(bus.grant), 32'b0000);
        drive(4'b0100, 8'b00_01_00_00, '0, '0, 4'b1111);
        tick();
        check("bp_grant", 32'(bus.grant), 32'b0100);
        drive('0, '0, '0, '0, 4'b1101);
        for (int c = 0; c < 100; c++) tick();
        check("bp_no_timeout", 32'(bus.grant), 32'b0100);
        drive('0, '0, 4'b0100, 4'b0100, 4'b1111);
        tick();
        drive('0, '0, '0, '0, 4'b1111);
        tick();

        // Stalled grant: input 0 on output 1, no beats
        drive(4'b0001, 8'b00_00_00_01, '0, '0, 4'b1111);
        tick();
        drive('0, '0, '0, '0, 4'b1111);
        for (int c = 0; c < MI - 1; c++) tick();
        check("wd_before", 32'(bus.grant), 32'b0001);
`ifdef XBAR_SCHED_TIMEOUT_EN
        tick();
        check("wd_pulse",   32'(bus.timeout_pulse), 32'b0010);
        check("wd_revoked", 32'(bus.grant),         32'b0000);
        tick();
        check("wd_pulse_end", 32'(bus.timeout_pulse), 32'b0000);
        // Last beat coinciding with the threshold: release, no pulse
        drive(4'b0001, 8'b00_00_00_01, '0, '0, 4'b1111);
        tick();
        drive('0, '0, '0, '0, 4'b1111);
        for (int c = 0; c < MI - 1; c++) tick();
        drive('0, '0, 4'b0001, 4'b0001, 4'b1111);
        tick();
        check("wd_tie_pulse", 32'(bus.timeout_pulse), 32'b0000);
        check("wd_tie_grant", 32'(bus.grant),         32'b0000);
`else
        for (int c = 0; c < 20; c++) tick();
        check("nowd_persist", 32'(bus.grant), 32'b0001);
        drive('0, '0, 4'b0001, 4'b0001, 4'b1111);
        tick();
`endif
        drive('0, '0, '0, '0, 4'b1111);
        tick();

        // Reset mid-packet: input 3 owns output 2 with ptr_2 advanced
        drive(4'b1000, 8'b10_00_00_00, '0, '0, 4'b1111);
        tick();
        drive('0, '0, 4'b1000, 4'b0000, 4'b1111);
        tick();
        rst = 1'b1;
        tick();
        check("mid_rst_grant", 32'(bus.grant),    32'b0000);
        check("mid_rst_busy",  32'(bus.out_busy), 32'b0000);
        rst = 1'b0;
        drive(4'b0101, 8'b00_10_00_10, '0, '0, 4'b1111);
        tick();
        check("post_rst_ptr", 32'(bus.grant), 32'b0001);
        drive('0, '0, 4'b0001, 4'b0001, 4'b1111);
        tick();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive(4'($urandom), 8'($urandom),
                  4'($urandom) & 4'($urandom) & 4'($urandom),
                  4'($urandom) & 4'($urandom),
                  4'($urandom) | 4'($urandom) | 4'($urandom));
            tick();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/xbar_out_sched.md
# xbar_out_sched

Per-output packet scheduler for the 4x4 switch crossbar. It sits between the per-input selector stage and the crossbar. Each input raises a request with a destination port. Each output port grants exactly one input at a time, chosen round-robin, and holds the grant for a whole packet. It also drives the crossbar's per-output source-select lines.

## Interface
Parameters:
- NUM_PORTS, 4, number of inputs = number of outputs; must equal 2**PORT_W
- PORT_W, 2, width of a port index
- MAX_IDLE, 64, idle cycles before a stalled grant is revoked (watchdog build only); range 2..65535

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_PORTS  input i has a packet head waiting
- req_dest  in  NUM_PORTS*PORT_W  destination of input i, bits [i*PORT_W +: PORT_W]; sampled only while req_valid[i]=1
- beat_valid  in  NUM_PORTS  input i transfers one 512-bit beat this cycle
- beat_last  in  NUM_PORTS  that beat ends the packet; ignored when beat_valid[i]=0
- out_ready  in  NUM_PORTS  output j (lookup stage) can accept data
- grant  out  NUM_PORTS  registered; input i owns an output
- out_sel  out  NUM_PORTS*PORT_W  registered; index of the input driving output j
- out_busy  out  NUM_PORTS  registered; output j is owned
- timeout_pulse  out  NUM_PORTS  registered; one-cycle pulse when output j's grant is revoked by the watchdog

## Operation
- There is one independent FSM per output j, with states IDLE and BUSY. Each FSM has a PORT_W-bit round-robin pointer ptr_j, an owner register owner_j, and a 16-bit idle counter.
- Candidates in IDLE for output j: input i where req_valid[i]=1, req_dest[i]=j, and grant[i]=0.
- IDLE → BUSY when out_ready[j]=1 and at least one candidate exists.
  - Winner = first candidate scanning ptr_j, ptr_j+1, … modulo NUM_PORTS.
  - The FSM sets owner_j=winner, out_sel[j]=winner, grant[winner]=1, out_busy[j]=1.
  - It clears the idle counter.
- IDLE with out_ready[j]=0 or no candidate: stay in IDLE, no change.
- Leaving BUSY:
  - BUSY → IDLE on beat_valid[owner]=1 and beat_last[owner]=1. The FSM clears grant[owner] and out_busy[j] and sets ptr_j = owner+1, wrapping at NUM_PORTS.
  - out_sel[j] keeps its last value in IDLE.
- Idle counter in BUSY:
  - Clears on any beat_valid[owner].
  - Holds while out_ready[j]=0 (downstream backpressure is not a stall).
  - Otherwise increments.
- No conflict between outputs: each input has exactly one destination, so no two output FSMs can select the same input in the same cycle.
- Candidates are only inputs with grant=0, so an input never holds two grants.
- beat_valid/beat_last from non-granted inputs are ignored.
- A change in req_dest while granted is ignored until release.
- Reset (rst=1 at an edge) mid-packet clears all state immediately. No release pulse is generated.
- Reset values:
  - grant=0, out_sel=0, out_busy=0, timeout_pulse=0.
  - All ptr_j=0, owner_j=0, idle counters=0, all FSMs IDLE.

## Timing
- Grant latency is 1 cycle. A request sampled at edge N gives grant/out_sel/out_busy valid after edge N; the input may send its first beat in cycle N+1.
- Release latency is 1 cycle. A last beat sampled at edge M gives grant low after edge M.
- The FSM spends at least one cycle in IDLE after each release. The earliest next grant for the same output is visible after edge M+1, so there are 2 cycles from last beat to new grant.
- A single-beat packet (beat_valid and beat_last in the first granted cycle) is legal and releases after that edge.
- Watchdog (only with XBAR_SCHED_TIMEOUT_EN): when the counter reaches MAX_IDLE-1 and increments at edge K:
  - grant, out_busy and the FSM state behave as a normal release.
  - ptr_j = owner+1.
  - timeout_pulse[j]=1 for exactly the cycle after edge K.
- If a last beat and the watchdog threshold coincide at the same edge, the last beat wins and there is no pulse.

## Configuration
- XBAR_SCHED_TIMEOUT_EN defined: idle counters, watchdog release and timeout_pulse are implemented as described.
- Not defined: no counters are synthesised, timeout_pulse is tied to 0, MAX_IDLE is unused, and BUSY is left only by a last beat.

## Test plan
- Single request: req_valid=0001 with dest 2 at edge 0 → grant=0001, out_sel[2]=0, out_busy=0100 after edge 0. A 3-beat packet with beat_last on beat 3 at edge 3 → grant=0000 after edge 3.
- Contention with round-robin rotation:
  - Inputs 1 and 3 both request dest 0, starting from ptr_0=0 → input 1 is granted first.
  - After its last beat → input 3 is granted 2 cycles later.
  - Repeat the same pair → input 1 is granted again.
- Parallel outputs: inputs 0,1,2,3 request dests 3,2,1,0 in the same cycle → grant=1111 after one edge, out_sel = {0,1,2,3} for outputs 3..0.
- Backpressure: out_ready[1]=0 while input 2 requests dest 1 → no grant. out_ready[1] rises at edge 5 → grant[2]=1 after edge 5. With out_ready low during BUSY for 100 cycles → no timeout.
- Watchdog (with XBAR_SCHED_TIMEOUT_EN, MAX_IDLE=8): input 0 is granted on output 1 and sends no beats → timeout_pulse=0010 for one cycle exactly 8 cycles after the grant, then grant=0000. Without the macro → the grant persists indefinitely.
- Reset mid-packet: rst=1 for one edge during BUSY → all outputs 0 after that edge, ptrs 0. The next request is granted normally.
